// File: rtl/disp_mode_pkg.sv
// Shared types and helpers for the display mode controller:
// FSM state encoding, edit-field codes and BCD increment.
package disp_mode_pkg;

    typedef enum logic [2:0] {
        CLK_SHOW = 3'd0,
        ALM_SHOW = 3'd1,
        SET_H    = 3'd2,
        SET_M    = 3'd3,
        BLANK    = 3'd4
    } state_t;

    localparam logic [1:0] SET_FIELD_NONE = 2'd0;
    localparam logic [1:0] SET_FIELD_H    = 2'd1;
    localparam logic [1:0] SET_FIELD_M    = 2'd2;

    // Two-digit BCD +1 that wraps to 00 once the value equals lim.
    function automatic logic [7:0] bcd_inc(
        input logic [7:0] v,
        input logic [7:0] lim
    );
        logic [7:0] r;
        if (v == lim)
            r = 8'h00;
        else if (v[3:0] == 4'd9)
            r = {v[7:4] + 4'd1, 4'd0};
        else
            r = {v[7:4], v[3:0] + 4'd1};
        return r;
    endfunction

endpackage

// File: rtl/disp_mode_ctrl_btn_debounce.sv
// Button conditioner: two-flop synchroniser, stability counter
// and a one-cycle pulse on each rising edge of the clean level.
module btn_debounce #(
    parameter int DEB_CYCLES = 16,
    parameter int CW         = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_btn,
    output logic o_pulse
);

    logic          r_s1;
    logic          r_s2;
    logic          r_lvl;
    logic          r_lvl_d;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1    <= 1'b0;
            r_s2    <= 1'b0;
            r_lvl   <= 1'b0;
            r_lvl_d <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_s1    <= i_btn;
            r_s2    <= r_s1;
            r_lvl_d <= r_lvl;
            if (r_s2 != r_lvl) begin
                if (r_cnt == CW'(DEB_CYCLES - 1)) begin
                    r_lvl <= r_s2;
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_pulse = r_lvl & ~r_lvl_d;

endmodule

// File: rtl/disp_mode_ctrl.sv
// Display mode sequencer: debounced buttons drive the clock/alarm
// view FSM, blank-frame strobe and the alarm HH:MM edit sequence.
module disp_mode_ctrl
    import disp_mode_pkg::*;
#(
    parameter int DEB_CYCLES     = 16,
    parameter int BLANK_CYCLES   = 8,
    parameter int BLINK_CYCLES   = 32,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CW             = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        btn_mode,
    input  logic        btn_next,
    input  logic        btn_inc,
    output logic        disp_sel,
    output logic        disp_blank,
    output logic [1:0]  set_field,
    output logic        blink_off,
    output logic [3:0]  alm_h_t,
    output logic [3:0]  alm_h_u,
    output logic [3:0]  alm_m_t,
    output logic [3:0]  alm_m_u,
    output logic [15:0] edit_val,
    output logic        busy
);

    logic w_mode, w_next, w_inc;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES), .CW(CW)) u_db_mode (
        .clk(clk), .rst_n(rst_n), .i_btn(btn_mode), .o_pulse(w_mode)
    );
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES), .CW(CW)) u_db_next (
        .clk(clk), .rst_n(rst_n), .i_btn(btn_next), .o_pulse(w_next)
    );
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES), .CW(CW)) u_db_inc (
        .clk(clk), .rst_n(rst_n), .i_btn(btn_inc), .o_pulse(w_inc)
    );

    state_t        r_state, w_state_nx;
    state_t        r_target, w_target_nx;
    logic [CW-1:0] r_cnt, w_cnt_nx;
    logic [CW-1:0] r_idle, w_idle_nx;
    logic [CW-1:0] r_bcnt, w_bcnt_nx;
    logic          r_phase, w_phase_nx;
    logic [15:0]   r_shadow, w_shadow_nx;
    logic [15:0]   r_alm, w_alm_nx;
    logic          r_disp_sel, w_disp_sel_nx;
    logic          r_disp_blank;
    logic [1:0]    r_set_field, w_set_field_nx;
    logic          r_blink_off;
    logic          w_in_set, w_in_set_nx;

    assign w_in_set    = (r_state == SET_H) || (r_state == SET_M);
    assign w_in_set_nx = (w_state_nx == SET_H) || (w_state_nx == SET_M);

    always_comb begin
        w_state_nx  = r_state;
        w_target_nx = r_target;
        w_cnt_nx    = '0;
        w_idle_nx   = '0;
        w_shadow_nx = r_shadow;
        w_alm_nx    = r_alm;
        unique case (r_state)
            BLANK: begin
                if (r_cnt == CW'(BLANK_CYCLES - 1))
                    w_state_nx = r_target;
                else
                    w_cnt_nx = r_cnt + 1'b1;
            end
            CLK_SHOW: begin
                if (w_mode) begin
                    w_state_nx  = BLANK;
                    w_target_nx = ALM_SHOW;
                end
            end
            ALM_SHOW: begin
                if (w_mode) begin
                    w_state_nx  = BLANK;
                    w_target_nx = CLK_SHOW;
                end else if (w_next) begin
                    w_state_nx  = SET_H;
                    w_shadow_nx = r_alm;
                end
            end
            SET_H, SET_M: begin
                w_idle_nx = r_idle + 1'b1;
                if (w_mode) begin
                    w_state_nx  = BLANK;
                    w_target_nx = CLK_SHOW;
                end else if (w_next) begin
                    w_idle_nx = '0;
                    if (r_state == SET_H) begin
                        w_state_nx = SET_M;
                    end else begin
                        w_alm_nx   = r_shadow;
                        w_state_nx = ALM_SHOW;
                    end
                end else if (w_inc) begin
                    w_idle_nx = '0;
                    if (r_state == SET_H)
                        w_shadow_nx[15:8] = bcd_inc(r_shadow[15:8], 8'h23);
                    else
                        w_shadow_nx[7:0] = bcd_inc(r_shadow[7:0], 8'h59);
                end else if (r_idle == CW'(TIMEOUT_CYCLES - 1)) begin
                    w_state_nx = ALM_SHOW;
                end
            end
            default: w_state_nx = BLANK;
        endcase
    end

    // Blink phase restarts on entry to hour edit, free-runs across SET_M.
    always_comb begin
        w_bcnt_nx  = '0;
        w_phase_nx = 1'b0;
        if (w_in_set_nx && w_in_set) begin
            if (r_bcnt == CW'(BLINK_CYCLES - 1)) begin
                w_phase_nx = ~r_phase;
            end else begin
                w_bcnt_nx  = r_bcnt + 1'b1;
                w_phase_nx = r_phase;
            end
        end
    end

    always_comb begin
        w_disp_sel_nx  = r_disp_sel;
        w_set_field_nx = SET_FIELD_NONE;
        if (w_state_nx != BLANK)
            w_disp_sel_nx = (w_state_nx != CLK_SHOW);
        if (w_state_nx == SET_H)
            w_set_field_nx = SET_FIELD_H;
        else if (w_state_nx == SET_M)
            w_set_field_nx = SET_FIELD_M;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= BLANK;
            r_target     <= CLK_SHOW;
            r_cnt        <= '0;
            r_idle       <= '0;
            r_bcnt       <= '0;
            r_phase      <= 1'b0;
            r_shadow     <= '0;
            r_alm        <= '0;
            r_disp_sel   <= 1'b0;
            r_disp_blank <= 1'b1;
            r_set_field  <= SET_FIELD_NONE;
            r_blink_off  <= 1'b0;
        end else begin
            r_state      <= w_state_nx;
            r_target     <= w_target_nx;
            r_cnt        <= w_cnt_nx;
            r_idle       <= w_idle_nx;
            r_bcnt       <= w_bcnt_nx;
            r_phase      <= w_phase_nx;
            r_shadow     <= w_shadow_nx;
            r_alm        <= w_alm_nx;
            r_disp_sel   <= w_disp_sel_nx;
            r_disp_blank <= (w_state_nx == BLANK);
            r_set_field  <= w_set_field_nx;
            r_blink_off  <= w_in_set_nx & w_phase_nx;
        end
    end

    assign disp_sel   = r_disp_sel;
    assign disp_blank = r_disp_blank;
    assign busy       = r_disp_blank;
    assign set_field  = r_set_field;
    assign blink_off  = r_blink_off;
    assign alm_h_t    = r_alm[15:12];
    assign alm_h_u    = r_alm[11:8];
    assign alm_m_t    = r_alm[7:4];
    assign alm_m_u    = r_alm[3:0];
    assign edit_val   = w_in_set ? r_shadow : r_alm;

endmodule

// File: tb/tb_disp_mode_ctrl.sv
// Self-checking bench for disp_mode_ctrl against a behavioural
// model of modes, alarm time and shadow time kept as integers.
module tb_disp_mode_ctrl;

    localparam int D  = 16;
    localparam int B  = 8;
    localparam int BL = 32;
    localparam int T  = 1024;

    logic        clk, rst_n, btn_mode, btn_next, btn_inc;
    logic        disp_sel, disp_blank, blink_off, busy;
    logic [1:0]  set_field;
    logic [3:0]  alm_h_t, alm_h_u, alm_m_t, alm_m_u;
    logic [15:0] edit_val;

    disp_mode_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .btn_mode(btn_mode), .btn_next(btn_next), .btn_inc(btn_inc),
        .disp_sel(disp_sel), .disp_blank(disp_blank),
        .set_field(set_field), .blink_off(blink_off),
        .alm_h_t(alm_h_t), .alm_h_u(alm_h_u),
        .alm_m_t(alm_m_t), .alm_m_u(alm_m_u),
        .edit_val(edit_val), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef enum int {M_CLK, M_ALM, M_SH, M_SM} mmode_t;

    int     total = 0;
    int     bad = 0;
    mmode_t mst = M_CLK;
    int     al_h = 0, al_m = 0, sh_h = 0, sh_m = 0;
    bit     seen_busy;

    function automatic logic [7:0] bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic logic [15:0] exp_alm();
        return {bcd(al_h), bcd(al_m)};
    endfunction

    function automatic logic [15:0] exp_edit();
        if (mst == M_SH || mst == M_SM)
            return {bcd(sh_h), bcd(sh_m)};
        return {bcd(al_h), bcd(al_m)};
    endfunction

    function automatic logic [1:0] exp_field();
        return (mst == M_SH) ? 2'd1 : (mst == M_SM) ? 2'd2 : 2'd0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Clean press and release of any button combination, plus model update.
    task automatic press(input bit m, input bit n, input bit i);
        seen_busy = 0;
        btn_mode = m; btn_next = n; btn_inc = i;
        repeat (D + 6) begin tick(); if (busy) seen_busy = 1; end
        btn_mode = 0; btn_next = 0; btn_inc = 0;
        repeat (D + 6) begin tick(); if (busy) seen_busy = 1; end
        if (m) begin
            mst = (mst == M_CLK) ? M_ALM : M_CLK;
        end else if (n) begin
            case (mst)
                M_ALM: begin mst = M_SH; sh_h = al_h; sh_m = al_m; end
                M_SH:  mst = M_SM;
                M_SM:  begin al_h = sh_h; al_m = sh_m; mst = M_ALM; end
                default: ;
            endcase
        end else if (i) begin
            if (mst == M_SH) sh_h = (sh_h + 1) % 24;
            else if (mst == M_SM) sh_m = (sh_m + 1) % 60;
        end
    endtask

    task automatic test_reset();
        int n;
        rst_n = 0; btn_mode = 0; btn_next = 0; btn_inc = 0;
        repeat (3) tick();
        total++;
        if ({busy, disp_blank} !== 2'b11) begin
            bad++; $display("FAIL reset_blank got=%b exp=11", {busy, disp_blank});
        end
        rst_n = 1;
        n = 0;
        while (busy && n < 100) begin tick(); n++; end
        total++;
        if (n != B) begin
            bad++; $display("FAIL reset_blank_len got=%0d exp=%0d", n, B);
        end
        mst = M_CLK; al_h = 0; al_m = 0;
        total++;
        if ({disp_sel, disp_blank, set_field, blink_off} !== 5'b0) begin
            bad++; $display("FAIL reset_outs got=%b exp=00000",
                {disp_sel, disp_blank, set_field, blink_off});
        end
        total++;
        if ({alm_h_t, alm_h_u, alm_m_t, alm_m_u} !== exp_alm() || edit_val !== exp_edit()) begin
            bad++; $display("FAIL reset_alarm got=%h/%h exp=%h",
                {alm_h_t, alm_h_u, alm_m_t, alm_m_u}, edit_val, exp_alm());
        end
    endtask

    task automatic test_debounce();
        int n;
        bit glitch_seen = 0;
        btn_mode = 1;
        repeat (D - 1) tick();
        btn_mode = 0;
        repeat (2 * D) begin tick(); if (busy || disp_sel) glitch_seen = 1; end
        total++;
        if (glitch_seen) begin
            bad++; $display("FAIL deb_glitch got=1 exp=0");
        end
        btn_mode = 1;
        n = 0;
        while (!busy && n < 100) begin tick(); n++; end
        total++;
        if (n != D + 3) begin
            bad++; $display("FAIL deb_latency got=%0d exp=%0d", n, D + 3);
        end
        n = 0;
        while (busy && n < 100) begin tick(); n++; end
        total++;
        if (n != B || disp_sel !== 1'b1) begin
            bad++; $display("FAIL deb_blank got=%0d sel=%b exp=%0d sel=1", n, disp_sel, B);
        end
        btn_mode = 0;
        repeat (D + 6) tick();
        mst = M_ALM;
    endtask

    task automatic test_edit_commit();
        press(0, 1, 0);
        total++;
        if (set_field !== exp_field() || edit_val !== exp_edit()) begin
            bad++; $display("FAIL edit_enter got=%0d/%h exp=%0d/%h",
                set_field, edit_val, exp_field(), exp_edit());
        end
        for (int k = 1; k <= 25; k++) begin
            press(0, 0, 1);
            if (k == 23) begin
                total++;
                if (edit_val[15:8] !== 8'h23) begin
                    bad++; $display("FAIL hour_23 got=%h exp=23", edit_val[15:8]);
                end
            end
        end
        total++;
        if (edit_val !== exp_edit()) begin
            bad++; $display("FAIL hour_wrap got=%h exp=%h", edit_val, exp_edit());
        end
        press(0, 1, 0);
        for (int k = 1; k <= 61; k++) begin
            press(0, 0, 1);
            if (k == 59) begin
                total++;
                if (edit_val[7:0] !== 8'h59) begin
                    bad++; $display("FAIL min_59 got=%h exp=59", edit_val[7:0]);
                end
            end
        end
        total++;
        if (set_field !== 2'd2 || edit_val !== exp_edit()) begin
            bad++; $display("FAIL min_wrap got=%0d/%h exp=2/%h", set_field, edit_val, exp_edit());
        end
        press(0, 1, 0);
        total++;
        if ({alm_h_t, alm_h_u, alm_m_t, alm_m_u} !== 16'h0101 ||
            set_field !== 2'd0 || disp_sel !== 1'b1 || busy !== 1'b0) begin
            bad++; $display("FAIL commit got=%h f=%0d sel=%b exp=0101 f=0 sel=1",
                {alm_h_t, alm_h_u, alm_m_t, alm_m_u}, set_field, disp_sel);
        end
    endtask

    task automatic test_abort_mode();
        press(0, 1, 0);
        repeat (6) press(0, 0, 1);
        press(0, 1, 0);
        repeat (59) press(0, 0, 1);
        press(0, 1, 0);
        total++;
        if ({alm_h_t, alm_h_u, alm_m_t, alm_m_u} !== exp_alm()) begin
            bad++; $display("FAIL set_0700 got=%h exp=%h",
                {alm_h_t, alm_h_u, alm_m_t, alm_m_u}, exp_alm());
        end
        press(0, 1, 0);
        repeat (5) press(0, 0, 1);
        press(0, 1, 0);
        repeat (34) press(0, 0, 1);
        total++;
        if (edit_val !== 16'h1234 || set_field !== 2'd2) begin
            bad++; $display("FAIL shadow_1234 got=%h/%0d exp=1234/2", edit_val, set_field);
        end
        press(1, 0, 0);
        total++;
        if (!seen_busy || disp_sel !== 1'b0 || set_field !== 2'd0 ||
            {alm_h_t, alm_h_u, alm_m_t, alm_m_u} !== 16'h0700 || edit_val !== exp_edit()) begin
            bad++; $display("FAIL abort_mode got=b%0d sel=%b alm=%h exp=b1 sel=0 alm=0700",
                seen_busy, disp_sel, {alm_h_t, alm_h_u, alm_m_t, alm_m_u});
        end
    endtask

    task automatic test_timeout();
        int n;
        press(1, 0, 0);
        btn_next = 1;
        n = 0;
        while (set_field != 2'd1 && n < 100) begin tick(); n++; end
        total++;
        if (set_field !== 2'd1 || blink_off !== 1'b0) begin
            bad++; $display("FAIL to_enter got=%0d/%b exp=1/0", set_field, blink_off);
        end
        btn_next = 0;
        mst = M_SH; sh_h = al_h; sh_m = al_m;
        n = 0;
        while (set_field != 2'd0 && n < T + 50) begin
            tick(); n++;
            if (n == BL) begin
                total++;
                if (blink_off !== 1'b1) begin
                    bad++; $display("FAIL blink_on got=%b exp=1", blink_off);
                end
            end
            if (n == 2 * BL) begin
                total++;
                if (blink_off !== 1'b0) begin
                    bad++; $display("FAIL blink_off got=%b exp=0", blink_off);
                end
            end
        end
        mst = M_ALM;
        total++;
        if (n != T) begin
            bad++; $display("FAIL timeout_len got=%0d exp=%0d", n, T);
        end
        total++;
        if (set_field !== 2'd0 || blink_off !== 1'b0 || disp_sel !== 1'b1 || busy !== 1'b0 ||
            {alm_h_t, alm_h_u, alm_m_t, alm_m_u} !== exp_alm()) begin
            bad++; $display("FAIL timeout_state got=%0d/%b/%b alm=%h exp=0/0/1 alm=%h",
                set_field, blink_off, disp_sel, {alm_h_t, alm_h_u, alm_m_t, alm_m_u}, exp_alm());
        end
    endtask

    task automatic test_priority();
        press(0, 1, 0);
        press(1, 0, 1);
        total++;
        if (!seen_busy || disp_sel !== 1'b0 || set_field !== 2'd0 ||
            {alm_h_t, alm_h_u, alm_m_t, alm_m_u} !== exp_alm()) begin
            bad++; $display("FAIL prio_mode_inc got=b%0d sel=%b alm=%h exp=b1 sel=0 alm=%h",
                seen_busy, disp_sel, {alm_h_t, alm_h_u, alm_m_t, alm_m_u}, exp_alm());
        end
        press(1, 0, 0);
        press(0, 1, 0);
        press(0, 1, 1);
        total++;
        if (set_field !== exp_field() || edit_val !== exp_edit()) begin
            bad++; $display("FAIL prio_next_inc got=%0d/%h exp=%0d/%h",
                set_field, edit_val, exp_field(), exp_edit());
        end
        press(0, 1, 0);
    endtask

    task automatic test_random_edit();
        int a, b;
        for (int it = 0; it < 4; it++) begin
            a = $urandom_range(0, 30);
            b = $urandom_range(0, 30);
            press(0, 1, 0);
            repeat (a) press(0, 0, 1);
            press(0, 1, 0);
            repeat (b) press(0, 0, 1);
            total++;
            if (set_field !== exp_field() || edit_val !== exp_edit()) begin
                bad++; $display("FAIL rnd_edit%0d got=%0d/%h exp=%0d/%h",
                    it, set_field, edit_val, exp_field(), exp_edit());
            end
            if ($urandom_range(0, 1) == 1) begin
                press(0, 1, 0);
            end else begin
                press(1, 0, 0);
                press(1, 0, 0);
            end
            total++;
            if ({alm_h_t, alm_h_u, alm_m_t, alm_m_u} !== exp_alm() ||
                disp_sel !== 1'b1 || set_field !== 2'd0) begin
                bad++; $display("FAIL rnd_end%0d got=%h sel=%b exp=%h sel=1",
                    it, {alm_h_t, alm_h_u, alm_m_t, alm_m_u}, disp_sel, exp_alm());
            end
        end
    endtask

    initial begin
        test_reset();
        test_debounce();
        test_edit_commit();
        test_abort_mode();
        test_timeout();
        test_priority();
        test_random_edit();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
